// File: rtl/execute_stage_pkg.sv
// Shared widths, opcode/ALU/forward/data-cache encodings and pipeline-register layouts
// for the RV32I execute stage.
package execute_stage_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned FSEL_W  = 2;
    localparam int unsigned DCC_W   = 3;

    typedef enum logic [OPC_W-1:0] {
        OpcOp     = 7'b0110011,
        OpcOpImm  = 7'b0010011,
        OpcLoad   = 7'b0000011,
        OpcStore  = 7'b0100011,
        OpcLui    = 7'b0110111,
        OpcAuipc  = 7'b0010111,
        OpcJal    = 7'b1101111,
        OpcJalr   = 7'b1100111,
        OpcBranch = 7'b1100011
    } opcode_e;

    typedef enum logic [ALUOP_W-1:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_op_e;

    typedef enum logic [FSEL_W-1:0] {
        FselReg   = 2'd0,
        FselExMem = 2'd1,
        FselMemWb = 2'd2,
        FselReg3  = 2'd3
    } fsel_e;

    typedef enum logic [DCC_W-1:0] {
        DccNone = 3'd0,
        DccLb   = 3'd1,
        DccLh   = 3'd2,
        DccLw   = 3'd3,
        DccLbu  = 3'd4,
        DccLhu  = 3'd5,
        DccSw   = 3'd6,
        DccSb   = 3'd7
    } dcc_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [REG_AW-1:0]  rs1_addr;
        logic [REG_AW-1:0]  rs2_addr;
        logic [REG_AW-1:0]  rd;
        logic [OPC_W-1:0]   opcode;
        logic [ALUOP_W-1:0] alu_op;
        logic [XLEN-1:0]    imm;
        logic [DCC_W-1:0]   dcc;
        logic               reg_we;
        logic               jal;
        logic               csl;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   rs2;
        logic [DCC_W-1:0]  dcc;
        logic              we;
        logic [REG_AW-1:0] rd;
        logic              csl;
    } ex_mem_t;

    // Selects 1 and 2 pick the in-flight results; 0 and 3 both keep the register value.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [FSEL_W-1:0] sel,
                                                input logic [XLEN-1:0]   reg_val,
                                                input logic [XLEN-1:0]   ex_mem_val,
                                                input logic [XLEN-1:0]   mem_wb_val);
        logic [XLEN-1:0] res;
        case (sel)
            FselExMem: res = ex_mem_val;
            FselMemWb: res = mem_wb_val;
            default:   res = reg_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational 32-bit ALU for the execute stage; ops 11-15 yield zero.
module exec_alu
    import execute_stage_pkg::*;
(
    input  logic [ALUOP_W-1:0] alu_op_i,
    input  logic [XLEN-1:0]    a_i,
    input  logic [XLEN-1:0]    b_i,
    output logic [XLEN-1:0]    result_o
);

    logic [4:0] shamt;

    assign shamt = b_i[4:0];

    // Decode the op into a single result word.
    always_comb begin
        result_o = '0;
        case (alu_op_i)
            AluAdd:   result_o = a_i + b_i;
            AluSub:   result_o = a_i - b_i;
            AluSll:   result_o = a_i << shamt;
            AluSlt:   result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            AluSltu:  result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            AluXor:   result_o = a_i ^ b_i;
            AluSrl:   result_o = a_i >> shamt;
            AluSra:   result_o = $unsigned($signed(a_i) >>> shamt);
            AluOr:    result_o = a_i | b_i;
            AluAnd:   result_o = a_i & b_i;
            AluPassB: result_o = b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: ID/EX register, forwarding operand muxes, ALU, EX/MEM register.
// Define EX_FORWARD_EN to honour fsel1/fsel2; otherwise operands come straight from the
// registered rs1/rs2 values and the hazard unit has to stall instead.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [XLEN-1:0]    pc_in,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic [REG_AW-1:0]  rs1_addr,
    input  logic [REG_AW-1:0]  rs2_addr,
    input  logic [REG_AW-1:0]  rd_addr,
    input  logic [OPC_W-1:0]   opcode_in,
    input  logic [ALUOP_W-1:0] alu_op_in,
    input  logic [XLEN-1:0]    imm_in,
    input  logic [DCC_W-1:0]   dcc_in,
    input  logic               reg_we_in,
    input  logic               jal_in,
    input  logic               csl_in,
    input  logic [FSEL_W-1:0]  fsel1,
    input  logic [FSEL_W-1:0]  fsel2,
    input  logic [XLEN-1:0]    wb_data,
    output logic [OPC_W-1:0]   ex_opcode,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [REG_AW-1:0]  ex_rs1,
    output logic [REG_AW-1:0]  ex_rs2,
    output logic [XLEN-1:0]    alu_result,
    output logic [XLEN-1:0]    mem_result,
    output logic [XLEN-1:0]    mem_rs2,
    output logic [DCC_W-1:0]   mem_dcc,
    output logic               mem_we,
    output logic [REG_AW-1:0]  mem_rd,
    output logic               mem_csl
);

    id_ex_t          id_ex_d, id_ex_q;
    ex_mem_t         ex_mem_d, ex_mem_q;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic [XLEN-1:0] op_a, op_b;
    logic [XLEN-1:0] alu_out;

    // ID/EX next state: a stall injects an all-zero bubble.
    always_comb begin
        id_ex_d = '0;
        if (!stall) begin
            id_ex_d.pc       = pc_in;
            id_ex_d.rs1_data = rs1_data;
            id_ex_d.rs2_data = rs2_data;
            id_ex_d.rs1_addr = rs1_addr;
            id_ex_d.rs2_addr = rs2_addr;
            id_ex_d.rd       = rd_addr;
            id_ex_d.opcode   = opcode_in;
            id_ex_d.alu_op   = alu_op_in;
            id_ex_d.imm      = imm_in;
            id_ex_d.dcc      = dcc_in;
            id_ex_d.reg_we   = reg_we_in;
            id_ex_d.jal      = jal_in;
            id_ex_d.csl      = csl_in;
        end
    end

    // ID/EX register; reset takes priority over stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

`ifdef EX_FORWARD_EN
    // Forward muxes look at the live EX/MEM and MEM/WB values, so dependencies resolve same-cycle.
    always_comb begin
        rs1_fwd = fwd_mux(fsel1, id_ex_q.rs1_data, ex_mem_q.result, wb_data);
        rs2_fwd = fwd_mux(fsel2, id_ex_q.rs2_data, ex_mem_q.result, wb_data);
    end
`else
    logic unused_fwd;

    // Forwarding disabled: selects and write-back data are deliberately ignored.
    always_comb begin
        unused_fwd = ^{fsel1, fsel2, wb_data};
        rs1_fwd    = id_ex_q.rs1_data;
        rs2_fwd    = id_ex_q.rs2_data;
    end
`endif

    // Operand selection: AUIPC uses the PC for A; only register-register ops use rs2 for B.
    always_comb begin
        op_a = rs1_fwd;
        op_b = id_ex_q.imm;
        if (id_ex_q.opcode == OpcAuipc) begin
            op_a = id_ex_q.pc;
        end
        if (id_ex_q.opcode == OpcOp) begin
            op_b = rs2_fwd;
        end
    end

    exec_alu u_alu (
        .alu_op_i (id_ex_q.alu_op),
        .a_i      (op_a),
        .b_i      (op_b),
        .result_o (alu_out)
    );

    // Link address overrides whatever the ALU computed.
    always_comb begin
        alu_result = alu_out;
        if (id_ex_q.jal) begin
            alu_result = id_ex_q.pc + 32'd4;
        end
    end

    // EX/MEM next state; store data is the forwarded rs2, not the raw register read.
    always_comb begin
        ex_mem_d        = '0;
        ex_mem_d.result = alu_result;
        ex_mem_d.rs2    = rs2_fwd;
        ex_mem_d.dcc    = id_ex_q.dcc;
        ex_mem_d.we     = id_ex_q.reg_we;
        ex_mem_d.rd     = id_ex_q.rd;
        ex_mem_d.csl    = id_ex_q.csl;
    end

    // EX/MEM register; never stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    // Drive the registered fields out to the hazard/forwarding units and the data cache.
    always_comb begin
        ex_opcode  = id_ex_q.opcode;
        ex_rd      = id_ex_q.rd;
        ex_rs1     = id_ex_q.rs1_addr;
        ex_rs2     = id_ex_q.rs2_addr;
        mem_result = ex_mem_q.result;
        mem_rs2    = ex_mem_q.rs2;
        mem_dcc    = ex_mem_q.dcc;
        mem_we     = ex_mem_q.we;
        mem_rd     = ex_mem_q.rd;
        mem_csl    = ex_mem_q.csl;
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage; forwarding expectations follow EX_FORWARD_EN.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] pc_in, rs1_data, rs2_data, imm_in, wb_data;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [6:0]  opcode_in;
    logic [3:0]  alu_op_in;
    logic [2:0]  dcc_in;
    logic        reg_we_in, jal_in, csl_in;
    logic [1:0]  fsel1, fsel2;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [31:0] alu_result, mem_result, mem_rs2;
    logic [2:0]  mem_dcc;
    logic        mem_we, mem_csl;
    logic [4:0]  mem_rd;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, ST = 7'b0100011;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    always #5 clk = ~clk;

    execute_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .pc_in      (pc_in),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .opcode_in  (opcode_in),
        .alu_op_in  (alu_op_in),
        .imm_in     (imm_in),
        .dcc_in     (dcc_in),
        .reg_we_in  (reg_we_in),
        .jal_in     (jal_in),
        .csl_in     (csl_in),
        .fsel1      (fsel1),
        .fsel2      (fsel2),
        .wb_data    (wb_data),
        .ex_opcode  (ex_opcode),
        .ex_rd      (ex_rd),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .alu_result (alu_result),
        .mem_result (mem_result),
        .mem_rs2    (mem_rs2),
        .mem_dcc    (mem_dcc),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd),
        .mem_csl    (mem_csl)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [3:0] op, input logic [31:0] pc,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                             input logic [4:0] rd, input logic [2:0] dcc, input logic we);
        opcode_in = opc;
        alu_op_in = op;
        pc_in     = pc;
        rs1_data  = a;
        rs2_data  = b;
        imm_in    = imm;
        rd_addr   = rd;
        dcc_in    = dcc;
        reg_we_in = we;
        jal_in    = 1'b0;
        csl_in    = 1'b0;
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd0;
    endtask

    initial begin
        // Reset held with random instruction fields; forward selects kept at register value.
        reset     = 1'b1;
        stall     = 1'($urandom);
        pc_in     = $urandom;
        rs1_data  = $urandom;
        rs2_data  = $urandom;
        imm_in    = $urandom;
        wb_data   = $urandom;
        rs1_addr  = 5'($urandom);
        rs2_addr  = 5'($urandom);
        rd_addr   = 5'($urandom);
        opcode_in = 7'($urandom);
        alu_op_in = 4'($urandom);
        dcc_in    = 3'($urandom);
        reg_we_in = 1'($urandom);
        jal_in    = 1'($urandom);
        csl_in    = 1'($urandom);
        fsel1     = 2'd0;
        fsel2     = 2'd0;
        #22;
        chk("rst_alu", alu_result, 32'd0);
        chk("rst_mem_result", mem_result, 32'd0);
        chk("rst_mem_rs2", mem_rs2, 32'd0);
        chk("rst_ctrl", {19'd0, mem_dcc, mem_we, mem_rd, mem_csl}, 32'd0);
        chk("rst_ex", {10'd0, ex_opcode, ex_rd, ex_rs1, ex_rs2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;

        // ADD 5+7
        set_instr(OP, 4'd0, 32'h0, 32'd5, 32'd7, 32'd0, 5'd3, 3'd0, 1'b1);
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        tick();
        chk("add_alu", alu_result, 32'd12);
        chk("add_ex_fields", {10'd0, ex_opcode, ex_rd, ex_rs1, ex_rs2},
            {10'd0, OP, 5'd3, 5'd1, 5'd2});
        chk("add_mem_not_yet", mem_result, 32'd0);

        // SUB 0-1
        set_instr(OP, 4'd1, 32'h0, 32'd0, 32'd1, 32'd0, 5'd4, 3'd0, 1'b1);
        tick();
        chk("add_mem_result", mem_result, 32'd12);
        chk("add_mem_ctrl", {26'd0, mem_we, mem_rd}, {26'd0, 1'b1, 5'd3});
        chk("sub_wrap", alu_result, 32'hFFFF_FFFF);

        // SRA 0x80000000 >>> 4 (imm)
        set_instr(OPI, 4'd7, 32'h0, 32'h8000_0000, 32'd0, 32'd4, 5'd5, 3'd0, 1'b1);
        tick();
        chk("sra", alu_result, 32'hF800_0000);
        chk("sub_mem_result", mem_result, 32'hFFFF_FFFF);

        set_instr(OP, 4'd3, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd5, 3'd0, 1'b1);
        tick();
        chk("slt_neg", alu_result, 32'd1);

        set_instr(OP, 4'd4, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd5, 3'd0, 1'b1);
        tick();
        chk("sltu_big", alu_result, 32'd0);

        set_instr(OPI, 4'd2, 32'h0, 32'd1, 32'd0, 32'd31, 5'd5, 3'd0, 1'b1);
        tick();
        chk("sll31", alu_result, 32'h8000_0000);

        set_instr(OP, 4'd6, 32'h0, 32'h8000_0000, 32'd36, 32'd0, 5'd5, 3'd0, 1'b1);
        tick();
        chk("srl_shamt_low5", alu_result, 32'h0800_0000);

        set_instr(OP, 4'd5, 32'h0, 32'hF0F0_1234, 32'h0FF0_1230, 32'd0, 5'd5, 3'd0, 1'b1);
        tick();
        chk("xor", alu_result, 32'hFF00_0004);

        set_instr(OP, 4'd11, 32'h0, 32'd3, 32'd4, 32'd0, 5'd5, 3'd0, 1'b1);
        tick();
        chk("op11_zero", alu_result, 32'd0);

        // Forwarding: produce 100 into EX/MEM, then ADDI with fsel1=1 and imm 3
        set_instr(OPI, 4'd0, 32'h0, 32'd100, 32'd0, 32'd0, 5'd6, 3'd0, 1'b1);
        tick();
        chk("fwd_setup", alu_result, 32'd100);
        set_instr(OPI, 4'd0, 32'h0, 32'd55, 32'd0, 32'd3, 5'd7, 3'd0, 1'b1);
        tick();
        fsel1 = 2'd1;
        #1;
        chk("fwd_mem_result", mem_result, 32'd100);
        chk("fwd1_exmem", alu_result, FWD ? 32'd103 : 32'd58);
        fsel1 = 2'd0;

        // OP SUB 20 - rs2, rs2 forwarded from wb_data=9
        set_instr(OP, 4'd1, 32'h0, 32'd20, 32'd4, 32'd0, 5'd8, 3'd0, 1'b1);
        tick();
        fsel2   = 2'd2;
        wb_data = 32'd9;
        #1;
        chk("fwd2_memwb", alu_result, FWD ? 32'd11 : 32'd16);
        fsel2 = 2'd0;

        // Store: address 8+4, store data forwarded from wb_data across the capture edge
        set_instr(ST, 4'd0, 32'h0, 32'd8, 32'd4, 32'd4, 5'd0, 3'd6, 1'b0);
        tick();
        chk("st_addr", alu_result, 32'd12);
        fsel2 = 2'd2;
        set_instr(7'd0, 4'd0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0);
        tick();
        fsel2 = 2'd0;
        chk("st_mem_rs2", mem_rs2, FWD ? 32'd9 : 32'd4);
        chk("st_mem_ctrl", {24'd0, mem_result[4:0], mem_dcc}, {24'd0, 5'd12, 3'd6});

        // Stall on a writing instruction inserts a bubble
        set_instr(OP, 4'd0, 32'h0, 32'd1, 32'd2, 32'd0, 5'd5, 3'd3, 1'b1);
        csl_in = 1'b1;
        stall  = 1'b1;
        tick();
        stall = 1'b0;
        chk("stall_ex", {20'd0, ex_opcode, ex_rd}, 32'd0);
        chk("stall_alu", alu_result, 32'd0);
        set_instr(OP, 4'd0, 32'h0, 32'd10, 32'd20, 32'd0, 5'd7, 3'd0, 1'b1);
        tick();
        chk("stall_mem_ctrl", {22'd0, mem_dcc, mem_we, mem_rd, mem_csl}, 32'd0);
        chk("post_stall_alu", alu_result, 32'd30);
        set_instr(7'd0, 4'd0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0);
        tick();
        chk("post_stall_mem", {mem_result[25:0], mem_we, mem_rd}, {26'd30, 1'b1, 5'd7});

        // JAL, AUIPC, LUI
        set_instr(JAL, 4'd0, 32'h40, 32'd0, 32'd0, 32'd8, 5'd1, 3'd0, 1'b1);
        jal_in = 1'b1;
        tick();
        chk("jal_link", alu_result, 32'h44);
        set_instr(AUIPC, 4'd0, 32'h100, 32'h5555, 32'd0, 32'h1000, 5'd2, 3'd0, 1'b1);
        tick();
        chk("auipc", alu_result, 32'h1100);
        chk("jal_mem", mem_result, 32'h44);
        set_instr(LUI, 4'd10, 32'h0, 32'h1234_5678, 32'd0, 32'hABCD_E000, 5'd2, 3'd0, 1'b1);
        tick();
        chk("lui", alu_result, 32'hABCD_E000);
        set_instr(OP, 4'd0, 32'h0, 32'd1, 32'd1, 32'd0, 5'd9, 3'd0, 1'b1);
        tick();
        chk("lui_mem", mem_result, 32'hABCD_E000);
        set_instr(7'd0, 4'd0, 32'h0, 32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0);
        tick();
        chk("pre_async_mem", {mem_result[25:0], mem_we, mem_rd}, {26'd2, 1'b1, 5'd9});

        // Asynchronous reset between edges
        set_instr(OP, 4'd0, 32'h0, 32'd3, 32'd3, 32'd0, 5'd4, 3'd2, 1'b1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_mem_result", mem_result, 32'd0);
        chk("async_mem_ctrl", {22'd0, mem_dcc, mem_we, mem_rd, mem_csl}, 32'd0);
        chk("async_ex", {20'd0, ex_opcode, ex_rd}, 32'd0);
        #2;
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
